// File: rtl/battleship_game_ctrl.sv
// Battleship game controller: ship-count decision, placement, alternating
// turns, victory/defeat, board cursor, ship/shot bitmaps, optional turn timer.
//
// Parameters: BOARD_N (board edge, 2..8), MAX_SHIPS (ship clamp),
//   TURN_TICKS (player-turn timeout in tick strobes).
// Ports:
//   clk, rst (sync, active-low), tick (timebase strobe)
//   move_up/down/left/right, confirm, player_fire : one-cycle pulses
//   ships_req [SW]      : requested ship count
//   pc_board [CELLS]    : PC ship bitmap, bit i*BOARD_N+j
//   pc_shot_valid, pc_shot_i, pc_shot_j : PC shot strobe and target
//   state [3]           : 0 DECISION, 1 PLACE, 2 PLAYER, 3 PC, 4 WIN, 5 LOSE
//   cursor_i/j, game_ships, ships_placed, player_left, pc_left,
//   player_board, player_shots, pc_shots, last_hit, turn_left : registered
// Optional feature macro: BATTLESHIP_TURN_TIMER_EN (per-turn timeout).
module battleship_game_ctrl #(
  parameter  int BOARD_N    = 5,
  parameter  int MAX_SHIPS  = 5,
  parameter  int TURN_TICKS = 15,
  localparam int CW    = $clog2(BOARD_N),
  localparam int SW    = $clog2(MAX_SHIPS + 1),
  localparam int CELLS = BOARD_N * BOARD_N,
  localparam int TW    = $clog2(TURN_TICKS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             move_up,
  input  logic             move_down,
  input  logic             move_left,
  input  logic             move_right,
  input  logic             confirm,
  input  logic             player_fire,
  input  logic [SW-1:0]    ships_req,
  input  logic [CELLS-1:0] pc_board,
  input  logic             pc_shot_valid,
  input  logic [CW-1:0]    pc_shot_i,
  input  logic [CW-1:0]    pc_shot_j,
  output logic [2:0]       state,
  output logic [CW-1:0]    cursor_i,
  output logic [CW-1:0]    cursor_j,
  output logic [SW-1:0]    game_ships,
  output logic [SW-1:0]    ships_placed,
  output logic [SW-1:0]    player_left,
  output logic [SW-1:0]    pc_left,
  output logic [CELLS-1:0] player_board,
  output logic [CELLS-1:0] player_shots,
  output logic [CELLS-1:0] pc_shots,
  output logic             last_hit,
  output logic [TW-1:0]    turn_left
);

  localparam logic [2:0] S_DEC    = 3'd0;
  localparam logic [2:0] S_PLACE  = 3'd1;
  localparam logic [2:0] S_PLAYER = 3'd2;
  localparam logic [2:0] S_PC     = 3'd3;
  localparam logic [2:0] S_WIN    = 3'd4;
  localparam logic [2:0] S_LOSE   = 3'd5;

  localparam logic [CELLS-1:0] ONE  = CELLS'(1);
  localparam logic [CW-1:0]    LAST = CW'(BOARD_N - 1);

  logic [CELLS-1:0] pc_latch;
  logic [SW-1:0]    eff;
  logic [CW-1:0]    ci_n;
  logic [CW-1:0]    cj_n;
  logic [CELLS-1:0] cur_mask;
  logic [CELLS-1:0] pc_mask;
  logic             pc_in;
  logic             place_ok;
  logic             place_last;
  logic             fire_ok;
  logic             fire_hit;
  logic             pc_hit;
  logic             clr;

  always_comb begin
    if (ships_req == '0)
      eff = SW'(1);
    else if (int'(ships_req) > MAX_SHIPS)
      eff = SW'(MAX_SHIPS);
    else
      eff = ships_req;
  end

  // Priority up > down > left > right, wrapping at the board edges.
  always_comb begin
    ci_n = cursor_i;
    cj_n = cursor_j;
    if (move_up)
      ci_n = (cursor_i == '0) ? LAST : cursor_i - CW'(1);
    else if (move_down)
      ci_n = (cursor_i == LAST) ? '0 : cursor_i + CW'(1);
    else if (move_left)
      cj_n = (cursor_j == '0) ? LAST : cursor_j - CW'(1);
    else if (move_right)
      cj_n = (cursor_j == LAST) ? '0 : cursor_j + CW'(1);
  end

  // Actions use the pre-move cursor.
  always_comb begin
    cur_mask = ONE << (int'(cursor_i) * BOARD_N + int'(cursor_j));
    pc_in = (int'(pc_shot_i) < BOARD_N) && (int'(pc_shot_j) < BOARD_N);
    pc_mask = '0;
    if (pc_in)
      pc_mask = ONE << (int'(pc_shot_i) * BOARD_N + int'(pc_shot_j));
    place_ok   = confirm && ((player_board & cur_mask) == '0);
    place_last = (ships_placed + SW'(1)) == game_ships;
    fire_ok    = player_fire && ((pc_shots & cur_mask) == '0);
    fire_hit   = (pc_latch & cur_mask) != '0;
    // A repeat cell or an off-board target counts as a miss.
    pc_hit = ((player_shots & pc_mask) == '0) &&
             ((player_board & pc_mask) != '0);
  end

  assign clr = !rst ||
               (((state == S_WIN) || (state == S_LOSE)) && confirm);

  always_ff @(posedge clk) begin
    if (clr) begin
      state        <= S_DEC;
      cursor_i     <= '0;
      cursor_j     <= '0;
      game_ships   <= '0;
      ships_placed <= '0;
      player_left  <= '0;
      pc_left      <= '0;
      player_board <= '0;
      player_shots <= '0;
      pc_shots     <= '0;
      pc_latch     <= '0;
      last_hit     <= 1'b0;
    end else begin
      case (state)
        S_DEC: begin
          game_ships <= eff;
          if (confirm) begin
            player_left <= eff;
            pc_left     <= eff;
            state       <= S_PLACE;
          end
        end
        S_PLACE: begin
          cursor_i <= ci_n;
          cursor_j <= cj_n;
          if (place_ok) begin
            player_board <= player_board | cur_mask;
            ships_placed <= ships_placed + SW'(1);
            if (place_last) begin
              state    <= S_PLAYER;
              pc_latch <= pc_board;
            end
          end
        end
        S_PLAYER: begin
          cursor_i <= ci_n;
          cursor_j <= cj_n;
          if (fire_ok) begin
            pc_shots <= pc_shots | cur_mask;
            last_hit <= fire_hit;
            if (fire_hit) begin
              pc_left <= pc_left - SW'(1);
              state   <= (pc_left == SW'(1)) ? S_WIN : S_PC;
            end else begin
              state <= S_PC;
            end
          end
`ifdef BATTLESHIP_TURN_TIMER_EN
          else if (tick && (turn_left == TW'(1))) begin
            state    <= S_PC;
            last_hit <= 1'b0;
          end
`endif
        end
        S_PC: begin
          if (pc_shot_valid) begin
            player_shots <= player_shots | pc_mask;
            last_hit     <= pc_hit;
            if (pc_hit) begin
              player_left <= player_left - SW'(1);
              state <= (player_left == SW'(1)) ? S_LOSE : S_PLAYER;
            end else begin
              state <= S_PLAYER;
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef BATTLESHIP_TURN_TIMER_EN
  // Reloaded on every entry to PLAYER; counts down only while it is set.
  always_ff @(posedge clk) begin
    if (clr) begin
      turn_left <= '0;
    end else if ((state == S_PLACE) && place_ok && place_last) begin
      turn_left <= TW'(TURN_TICKS);
    end else if ((state == S_PC) && pc_shot_valid &&
                 !(pc_hit && (player_left == SW'(1)))) begin
      turn_left <= TW'(TURN_TICKS);
    end else if ((state == S_PLAYER) && tick && (turn_left != '0)) begin
      turn_left <= turn_left - TW'(1);
    end
  end
`else
  logic unused_tick;
  assign unused_tick = tick;
  assign turn_left   = '0;
`endif

endmodule

// File: tb/tb_battleship_game_ctrl.sv
// Directed bench for battleship_game_ctrl: decision, cursor, placement,
// turns, win/lose, restart and (when compiled in) the turn timer.
module tb_battleship_game_ctrl;

  localparam int BN = 5;
  localparam int MS = 5;
  localparam int TT = 3;
  localparam int CW = $clog2(BN);
  localparam int SW = $clog2(MS + 1);
  localparam int CL = BN * BN;
  localparam int TW = $clog2(TT + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          tick = 1'b0;
  logic          move_up = 1'b0;
  logic          move_down = 1'b0;
  logic          move_left = 1'b0;
  logic          move_right = 1'b0;
  logic          confirm = 1'b0;
  logic          player_fire = 1'b0;
  logic [SW-1:0] ships_req = '0;
  logic [CL-1:0] pc_board = '0;
  logic          pc_shot_valid = 1'b0;
  logic [CW-1:0] pc_shot_i = '0;
  logic [CW-1:0] pc_shot_j = '0;
  logic [2:0]    state;
  logic [CW-1:0] cursor_i;
  logic [CW-1:0] cursor_j;
  logic [SW-1:0] game_ships;
  logic [SW-1:0] ships_placed;
  logic [SW-1:0] player_left;
  logic [SW-1:0] pc_left;
  logic [CL-1:0] player_board;
  logic [CL-1:0] player_shots;
  logic [CL-1:0] pc_shots;
  logic          last_hit;
  logic [TW-1:0] turn_left;

  int errors = 0;
  int checks = 0;

  battleship_game_ctrl #(
    .BOARD_N(BN), .MAX_SHIPS(MS), .TURN_TICKS(TT)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick),
    .move_up(move_up), .move_down(move_down),
    .move_left(move_left), .move_right(move_right),
    .confirm(confirm), .player_fire(player_fire),
    .ships_req(ships_req), .pc_board(pc_board),
    .pc_shot_valid(pc_shot_valid),
    .pc_shot_i(pc_shot_i), .pc_shot_j(pc_shot_j),
    .state(state), .cursor_i(cursor_i), .cursor_j(cursor_j),
    .game_ships(game_ships), .ships_placed(ships_placed),
    .player_left(player_left), .pc_left(pc_left),
    .player_board(player_board), .player_shots(player_shots),
    .pc_shots(pc_shots), .last_hit(last_hit), .turn_left(turn_left)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
    tick = 0; move_up = 0; move_down = 0; move_left = 0;
    move_right = 0; confirm = 0; player_fire = 0; pc_shot_valid = 0;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pc_shot(input int i, input int j);
    pc_shot_i = CW'(i);
    pc_shot_j = CW'(j);
    pc_shot_valid = 1;
    cyc();
  endtask

  initial begin
    cyc(); cyc();
    chk("rst_state", state, 0);
    chk("rst_ci", cursor_i, 0);
    chk("rst_cj", cursor_j, 0);
    chk("rst_gs", game_ships, 0);
    chk("rst_pl", player_left, 0);
    chk("rst_pcl", pc_left, 0);
    chk("rst_pb", player_board, 0);
    chk("rst_ps", player_shots, 0);
    chk("rst_pcs", pc_shots, 0);
    chk("rst_lh", last_hit, 0);
    chk("rst_tl", turn_left, 0);

    rst = 1; ships_req = 0; cyc();
    chk("clamp0", game_ships, 1);
    ships_req = 7; cyc();
    chk("clamp7", game_ships, 5);
    ships_req = 3; cyc();
    chk("pass3", game_ships, 3);
    ships_req = 7; confirm = 1; cyc();
    chk("dec_state", state, 1);
    chk("dec_gs", game_ships, 5);
    chk("dec_pl", player_left, 5);
    chk("dec_pcl", pc_left, 5);

    rst = 0; confirm = 1; move_up = 1; cyc();
    chk("midrst_state", state, 0);
    chk("midrst_pl", player_left, 0);
    chk("midrst_ci", cursor_i, 0);
    rst = 1;

    ships_req = 2; confirm = 1; cyc();
    chk("g1_state", state, 1);
    chk("g1_gs", game_ships, 2);
    move_up = 1; cyc();
    chk("up_wrap", cursor_i, 4);
    move_left = 1; cyc();
    chk("left_wrap", cursor_j, 4);
    move_up = 1; move_right = 1; cyc();
    chk("prio_i", cursor_i, 3);
    chk("prio_j", cursor_j, 4);
    move_down = 1; cyc();
    move_down = 1; cyc();
    chk("down_wrap", cursor_i, 0);
    move_right = 1; cyc();
    chk("right_wrap", cursor_j, 0);

    confirm = 1; cyc();
    chk("place1", ships_placed, 1);
    chk("place1_pb", player_board, 1);
    confirm = 1; cyc();
    chk("place_dup", ships_placed, 1);
    move_right = 1; confirm = 1; cyc();
    chk("mvconf_sp", ships_placed, 1);
    chk("mvconf_cj", cursor_j, 1);
    pc_board = (25'd1 << 1) | (25'd1 << 6);
    confirm = 1; cyc();
    chk("place2", ships_placed, 2);
    chk("place2_st", state, 2);
    chk("place2_pb", player_board, 3);
    pc_board = '0;

    player_fire = 1; cyc();
    chk("hit_pcl", pc_left, 1);
    chk("hit_lh", last_hit, 1);
    chk("hit_st", state, 3);
    chk("hit_pcs", pc_shots, 2);

    pc_shot(0, 0);
    chk("pch_pl", player_left, 1);
    chk("pch_ps", player_shots, 1);
    chk("pch_st", state, 2);

    player_fire = 1; cyc();
    chk("refire_st", state, 2);
    chk("refire_pcl", pc_left, 1);
    move_left = 1; cyc();
    player_fire = 1; cyc();
    chk("miss_lh", last_hit, 0);
    chk("miss_st", state, 3);
    chk("miss_pcs", pc_shots, 3);

    pc_shot(0, 0);
    chk("rep_pl", player_left, 1);
    chk("rep_st", state, 2);

    move_down = 1; player_fire = 1; cyc();
    chk("mvfire_st", state, 2);
    chk("mvfire_ci", cursor_i, 1);
    player_fire = 1; cyc();
    chk("miss2_st", state, 3);
    pc_shot(0, 1);
    chk("lose_pl", player_left, 0);
    chk("lose_st", state, 5);
    chk("lose_ps", player_shots, 3);
    player_fire = 1; cyc();
    chk("lose_hold", state, 5);
    confirm = 1; cyc();
    chk("rs_state", state, 0);
    chk("rs_pb", player_board, 0);
    chk("rs_sp", ships_placed, 0);
    chk("rs_pcs", pc_shots, 0);
    chk("rs_ps", player_shots, 0);
    chk("rs_ci", cursor_i, 0);
    chk("rs_gs", game_ships, 0);

    ships_req = 1; pc_board = 25'd1; confirm = 1; cyc();
    chk("g2_gs", game_ships, 1);
    confirm = 1; cyc();
    chk("g2_st", state, 2);
`ifdef BATTLESHIP_TURN_TIMER_EN
    chk("tm_load", turn_left, 3);
    tick = 1; cyc();
    chk("tm_dec", turn_left, 2);
    tick = 1; cyc();
    tick = 1; cyc();
    chk("tm_forfeit", state, 3);
    chk("tm_lh", last_hit, 0);
    pc_shot(4, 4);
    chk("tm_back", state, 2);
    chk("tm_reload", turn_left, 3);
    tick = 1; cyc();
    tick = 1; cyc();
    tick = 1; player_fire = 1; cyc();
`else
    chk("notm_tl", turn_left, 0);
    tick = 1; cyc();
    tick = 1; cyc();
    tick = 1; cyc();
    chk("notm_st", state, 2);
    player_fire = 1; cyc();
`endif
    chk("win_st", state, 4);
    chk("win_pcl", pc_left, 0);
    chk("win_lh", last_hit, 1);
    chk("win_pcs", pc_shots, 1);
    confirm = 1; cyc();
    chk("clr_st", state, 0);
    chk("clr_lh", last_hit, 0);
    chk("clr_pcs", pc_shots, 0);
    chk("clr_pcl", pc_left, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/battleship_game_ctrl.md
# battleship_game_ctrl

Parametrised game controller for the Battleship lab: the next generation of the fixed 5-ship, 3-bit top level. It owns the full game state machine (ship-count decision, placement, alternating turns, victory/defeat), the board cursor, the player's ship bitmap, shot bookkeeping for both sides and an optional per-turn timeout. It sits between the debounced button/switch inputs and the VGA renderer and seven-segment decoders, which consume its registered outputs.

## Interface
- BOARD_N, 5: board is BOARD_N x BOARD_N cells, 2..8
- MAX_SHIPS, 5: upper clamp for requested ship count, 1..BOARD_N*BOARD_N
- TURN_TICKS, 15: player-turn timeout in `tick` strobes (used only with timer enabled)
- Derived: CW = $clog2(BOARD_N), SW = $clog2(MAX_SHIPS+1), CELLS = BOARD_N*BOARD_N, TW = $clog2(TURN_TICKS+1)
- clk  in  1  system clock; the only clock
- rst  in  1  synchronous, active-low reset
- tick  in  1  one-cycle timebase strobe (e.g. 1 s)
- move_up, move_down, move_left, move_right  in  1 each  one-cycle debounced pulses
- confirm  in  1  one-cycle pulse: accept count / place ship / restart
- player_fire  in  1  one-cycle pulse: shoot at cursor
- ships_req  in  SW  requested ship count (switches)
- pc_board  in  CELLS  PC ship bitmap, bit index i*BOARD_N+j; sampled when entering PLAYER_TURN first time
- pc_shot_valid  in  1  PC shot strobe; pc_shot_i, pc_shot_j  in  CW each  PC target
- state  out  3  DECISION=0, PLACE=1, PLAYER=2, PC=3, WIN=4, LOSE=5
- cursor_i, cursor_j  out  CW  cursor row/column
- game_ships  out  SW  locked ship count; ships_placed  out  SW
- player_left, pc_left  out  SW  surviving ships per side
- player_board, player_shots, pc_shots  out  CELLS  bitmaps for the renderer
- last_hit  out  1  most recent resolved shot was a hit
- turn_left  out  TW  remaining ticks (0 when timer compiled out)

## Operation
- Reset (rst=0 at clk edge): state=DECISION, cursor 0,0, all counts 0, all bitmaps 0, last_hit=0, turn_left=0, latched pc board 0.
- Clamp: eff = 1 if ships_req==0, MAX_SHIPS if ships_req>MAX_SHIPS, else ships_req. game_ships shows eff continuously in DECISION, then frozen.
- DECISION: confirm -> lock game_ships=eff, player_left=pc_left=eff, -> PLACE.
- Cursor (PLACE, PLAYER only): priority up>down>left>right, one move per cycle; wrap-around: up at row 0 -> BOARD_N-1, down at BOARD_N-1 -> 0, same for columns.
- PLACE: confirm on empty cell sets player_board bit, ships_placed+1; confirm on occupied cell ignored. When ships_placed reaches game_ships -> PLAYER (same edge as last placement). Latch pc_board on that edge.
- PLAYER: player_fire on unshot cell sets pc_shots bit; hit if latched pc bit set -> pc_left-1, last_hit=1, else last_hit=0. If pc_left becomes 0 -> WIN, else -> PC. Fire on already-shot cell ignored, turn stays.
- PC: pc_shot_valid sets player_shots bit; hit on unshot occupied cell -> player_left-1; repeat cell is a miss. Always leaves PC: -> LOSE if player_left becomes 0, else -> PLAYER.
- WIN/LOSE: outputs hold; confirm -> full clear as reset, -> DECISION.
- Simultaneous move + confirm/fire: action uses pre-move cursor; cursor moves the same edge.
- Inputs not listed for a state are ignored.

## Timing
- All outputs registered; every effect visible the cycle after the input pulse.
- State transition latency: 1 cycle from confirm/fire/pc_shot_valid.
- Counts never underflow: decrement only on verified new hit.
- Reset mid-game takes priority over every other input that cycle.

## Configuration
- BATTLESHIP_TURN_TIMER_EN defined: on entry to PLAYER turn_left=TURN_TICKS; each tick decrements; tick with turn_left==1 and no fire in same cycle -> forfeits turn, -> PC, last_hit=0. Fire and expiring tick in same cycle: fire wins.
- Undefined: no timer logic, turn_left tied 0, player turn unbounded.

## Test plan
- ships_req=7, MAX_SHIPS=5, confirm -> game_ships=5, player_left=pc_left=5, state=PLACE next cycle; ships_req=0 -> game_ships=1.
- At cursor 0,0 pulse move_up then move_left -> cursor 4,4; up+right same cycle -> only up applied.
- game_ships=2: confirm at 0,0 twice -> ships_placed=1; move_right, confirm -> ships_placed=2, state=PLAYER.
- pc_board bit 0 only, game_ships=1: fire at 0,0 -> pc_left=0, last_hit=1, state=WIN; confirm -> DECISION, all cleared.
- PC turn: pc_shot at player ship twice across turns -> player_left decrements once; final hit -> LOSE.
- Timer enabled, TURN_TICKS=3: three ticks no fire -> state=PC; fire coincident with third tick -> shot resolved, no forfeit.
